// File: rtl/cache_define.sv
// Shared definitions for the trace command front end.
// Contents: trace command codes, boolean constants, queue state encoding,
// default cache geometry, and a helper that classifies legal command codes.
package cache_define;

  typedef enum logic [3:0] {
    READ_D   = 4'd0,
    WRITE_D  = 4'd1,
    READ_I   = 4'd2,
    SNP_INV  = 4'd3,
    SNP_RD   = 4'd4,
    SNP_WR   = 4'd5,
    SNP_RWIM = 4'd6,
    CLEAR    = 4'd8,
    PRINT    = 4'd9
  } trace_cmd_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    Q_IDLE  = 2'd0,
    Q_RUN   = 2'd1,
    Q_DRAIN = 2'd2,
    Q_DONE  = 2'd3
  } q_state_e;

  localparam int CMD_W           = 4;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_OFFSET_BITS = 6;
  localparam int DEF_INDEX_BITS  = 14;

  function automatic logic is_legal_cmd(input logic [3:0] cmd);
    logic legal;
    legal = FALSE;
    case (cmd)
      READ_D, WRITE_D, READ_I, SNP_INV, SNP_RD, SNP_WR, SNP_RWIM, CLEAR, PRINT:
        legal = TRUE;
      default: legal = FALSE;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through FIFO with registered write (no write-to-read bypass).
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head entry),
// mark_tail sets bit 0 of the most recently written entry, full, empty,
// single (exactly one entry held).
module cmd_fifo
  import cache_define::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             mark_tail,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, tail_ptr, fill;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign fill     = wr_ptr - rd_ptr;
  assign single   = (fill == {{AW{1'b0}}, 1'b1});
  assign tail_ptr = wr_ptr - {{AW{1'b0}}, 1'b1};
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rdata    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      // Only reached with no push in the same cycle, so tail_ptr is the last write.
      if (mark_tail && !empty) mem[tail_ptr[AW-1:0]][0] <= TRUE;
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/trace_cmd_queue.sv
// Front end between the trace parser and the LLC model: validates command
// codes, queues legal commands, splits the address into tag/index/offset,
// and tracks end-of-trace through to a sticky done.
// Ports: clk, rst_n; in_valid/in_ready/in_cmd/in_addr/in_eof (parser side);
// out_valid/out_ready/out_cmd/out_tag/out_index/out_offset/out_last (cache
// side); err_pulse, err_sticky, done.
// Build option: TRACE_STATS_EN adds saturating stat_rd/stat_wr/stat_snoop/
// stat_drop counters.
//
// state   | meaning
// Q_IDLE  | nothing accepted yet
// Q_RUN   | accepting trace commands
// Q_DRAIN | end of trace seen, issuing remaining entries, input closed
// Q_DONE  | final command issued, holds until reset
module trace_cmd_queue
  import cache_define::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS,
  parameter int INDEX_BITS  = DEF_INDEX_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [3:0]                           in_cmd,
  input  logic [ADDR_W-1:0]                    in_addr,
  input  logic                                 in_eof,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [3:0]                           out_cmd,
  output logic [ADDR_W-INDEX_BITS-OFFSET_BITS-1:0] out_tag,
  output logic [INDEX_BITS-1:0]                out_index,
  output logic [OFFSET_BITS-1:0]               out_offset,
  output logic                                 out_last,
  output logic                                 err_pulse,
  output logic                                 err_sticky,
  output logic                                 done
`ifdef TRACE_STATS_EN
  ,
  output logic [31:0]                          stat_rd,
  output logic [31:0]                          stat_wr,
  output logic [31:0]                          stat_snoop,
  output logic [15:0]                          stat_drop
`endif
);

  // Entry layout: {cmd, addr, last}
  localparam int WIDTH = CMD_W + ADDR_W + 1;
  localparam int LO_IX = OFFSET_BITS + 1;
  localparam int LO_TG = OFFSET_BITS + INDEX_BITS + 1;

  q_state_e         state;
  logic [WIDTH-1:0] head;
  logic             full, empty, single;
  logic             open, legal, accept, push, pop, eof_evt, mark;

  assign open     = (state == Q_IDLE) || (state == Q_RUN);
  assign in_ready = open && !full;
  assign legal    = is_legal_cmd(in_cmd);
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;
  // End of trace counts unless it rides on a beat that is being held off.
  assign eof_evt  = in_eof && open && (!in_valid || !full);
  // Eof without an enqueue flags whatever entry was queued last.
  assign mark     = eof_evt && !push;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     ({in_cmd, in_addr, in_eof}),
    .pop       (pop),
    .mark_tail (mark),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .single    (single)
  );

  assign out_valid  = !empty;
  assign out_cmd    = head[WIDTH-1 -: CMD_W];
  assign out_tag    = head[ADDR_W:LO_TG];
  assign out_index  = head[LO_TG-1:LO_IX];
  assign out_offset = head[LO_IX-1:1];
  assign out_last   = head[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= Q_IDLE;
      done       <= FALSE;
      err_pulse  <= FALSE;
      err_sticky <= FALSE;
    end else begin
      err_pulse <= accept && !legal;
      if (accept && !legal) err_sticky <= TRUE;
      case (state)
        Q_IDLE, Q_RUN: begin
          if (eof_evt) begin
            // Nothing left to issue after this edge: finish without draining.
            if (!push && (empty || (single && pop))) begin
              state <= Q_DONE;
              done  <= TRUE;
            end else begin
              state <= Q_DRAIN;
            end
          end else if (accept) begin
            state <= Q_RUN;
          end
        end
        Q_DRAIN: begin
          if ((pop && out_last) || empty) begin
            state <= Q_DONE;
            done  <= TRUE;
          end
        end
        Q_DONE:  state <= Q_DONE;
        default: state <= Q_IDLE;
      endcase
    end
  end

`ifdef TRACE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_snoop <= '0;
      stat_drop  <= '0;
    end else begin
      if (pop) begin
        case (out_cmd)
          READ_D, READ_I:
            if (stat_rd != '1) stat_rd <= stat_rd + 32'd1;
          WRITE_D:
            if (stat_wr != '1) stat_wr <= stat_wr + 32'd1;
          SNP_INV, SNP_RD, SNP_WR, SNP_RWIM:
            if (stat_snoop != '1) stat_snoop <= stat_snoop + 32'd1;
          default: ;
        endcase
      end
      if (accept && !legal && (stat_drop != '1)) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_cmd_queue.sv
module tb_trace_cmd_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int OFF_B  = 6;
  localparam int IDX_B  = 14;
  localparam int TAG_W  = ADDR_W - IDX_B - OFF_B;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_cmd = '0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              in_eof = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_cmd;
  logic [TAG_W-1:0]  out_tag;
  logic [IDX_B-1:0]  out_index;
  logic [OFF_B-1:0]  out_offset;
  logic              out_last;
  logic              err_pulse, err_sticky, done;
`ifdef TRACE_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_snoop;
  logic [15:0] stat_drop;
`endif

  trace_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFFSET_BITS(OFF_B), .INDEX_BITS(IDX_B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_addr    (in_addr),
    .in_eof     (in_eof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cmd    (out_cmd),
    .out_tag    (out_tag),
    .out_index  (out_index),
    .out_offset (out_offset),
    .out_last   (out_last),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .done       (done)
`ifdef TRACE_STATS_EN
    ,
    .stat_rd    (stat_rd),
    .stat_wr    (stat_wr),
    .stat_snoop (stat_snoop),
    .stat_drop  (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of queued commands plus trace-level flags.
  typedef struct {
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
    bit                last;
  } ent_t;

  ent_t m_q[$];
  bit   m_closed, m_done, m_errp, m_sticky;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [ADDR_W-1:0] a;
    chk("in_ready", in_ready, (!m_closed && m_q.size() < DEPTH));
    chk("out_valid", out_valid, (m_q.size() > 0));
    if (m_q.size() > 0) begin
      a = m_q[0].addr;
      chk("out_cmd", out_cmd, m_q[0].cmd);
      chk("out_tag", out_tag, a / (2 ** (OFF_B + IDX_B)));
      chk("out_index", out_index, (a / (2 ** OFF_B)) % (2 ** IDX_B));
      chk("out_offset", out_offset, a % (2 ** OFF_B));
      chk("out_last", out_last, m_q[0].last);
    end
    chk("err_pulse", err_pulse, m_errp);
    chk("err_sticky", err_sticky, m_sticky);
    chk("done", done, m_done);
  endtask

  task automatic model_update(input logic v, input logic [3:0] c, input logic [ADDR_W-1:0] a,
                              input logic e, input logic r);
    int sz;
    bit acc, lg, eofe;
    sz   = m_q.size();
    acc  = v && !m_closed && (sz < DEPTH);
    lg   = (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
    eofe = e && !m_closed && (!v || sz < DEPTH);
    m_errp = acc && !lg;
    if (m_errp) m_sticky = 1'b1;
    if (sz > 0 && r) void'(m_q.pop_front());
    if (acc && lg) m_q.push_back('{cmd: c, addr: a, last: e});
    if (eofe) begin
      m_closed = 1'b1;
      if (!(acc && lg) && m_q.size() > 0) m_q[m_q.size()-1].last = 1'b1;
    end
    if (m_closed && m_q.size() == 0) m_done = 1'b1;
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic [ADDR_W-1:0] a,
                      input logic e, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_cmd    = c;
    in_addr   = a;
    in_eof    = e;
    out_ready = r;
    #1;
    check_outputs();
    model_update(v, c, a, e, r);
  endtask

  // Asserted between clock edges so the clear can only come from the async path.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_eof = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err_sticky", err_sticky, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_cmd", out_cmd, 4'd0);
    m_q.delete();
    m_closed = 0; m_done = 0; m_errp = 0; m_sticky = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a;
    int          pct;

    do_reset();

    // Address split of a known value.
    step(1, 4'd0, 32'h1234_5678, 0, 0);
    step(0, 4'd0, 32'h0, 0, 0);
    chk("split_tag", out_tag, 12'h123);
    chk("split_index", out_index, 14'h1159);
    chk("split_offset", out_offset, 6'h38);

    // Illegal codes are dropped with a pulse each.
    do_reset();
    step(1, 4'd7, 32'hA, 0, 0);
    step(1, 4'd12, 32'hB, 0, 0);
    step(0, 4'd0, 32'h0, 0, 0);
    step(0, 4'd0, 32'h0, 0, 0);
    chk("drop_sticky", err_sticky, 1'b1);
    chk("drop_no_valid", out_valid, 1'b0);

    // Fill with the sink stalled, hold a ninth beat, then full pop+push, then drain.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 4'(i % 7), 32'h1000 * (i + 1) + 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'd9, 32'hDEAD_BEEF, 0, 0);
    chk("full_in_ready", in_ready, 1'b0);
    step(1, 4'd9, 32'hDEAD_BEEF, 0, 1);
    step(1, 4'd9, 32'hDEAD_BEEF, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 4'd0, 32'h0, 0, 1);

    // Three commands, the third closes the trace.
    do_reset();
    step(1, 4'd1, 32'h40, 0, 0);
    step(1, 4'd2, 32'h80, 0, 0);
    step(1, 4'd3, 32'hC0, 1, 0);
    step(1, 4'd4, 32'h100, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'd0, 32'h0, 0, 1);
    chk("eof_done", done, 1'b1);

    // End of trace on an illegal beat and on an idle beat.
    do_reset();
    step(1, 4'd5, 32'h1, 0, 0);
    step(1, 4'd6, 32'h2, 0, 0);
    step(1, 4'd13, 32'h3, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 4'd0, 32'h0, 0, 1);
    do_reset();
    step(1, 4'd8, 32'h5, 0, 0);
    step(0, 4'd0, 32'h0, 1, 1);
    step(0, 4'd0, 32'h0, 0, 1);
    do_reset();
    step(0, 4'd0, 32'h0, 1, 0);
    step(0, 4'd0, 32'h0, 0, 0);

    // Reset with four entries queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 4'd1, 32'(i * 64), 0, 0);
    step(1, 4'd7, 32'h0, 0, 0);
    do_reset();

    // Randomized traces.
    for (int ep = 0; ep < 14; ep++) begin
      do_reset();
      pct = $urandom_range(20, 90);
      for (int cyc = 0; cyc < 90; cyc++) begin
        c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
        a = $urandom;
        step(($urandom_range(0, 99) < 70), c, a, ($urandom_range(0, 99) < 3),
             ($urandom_range(0, 99) < pct));
        if (ep % 4 == 3 && cyc == 45) do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
